ram_arbiter: RTL
================

# ram_arbiter

Shares the single 16-bit external RAM port between the instruction-side and data-side refill/writeback requesters. It sits between the cache miss handling and the RAM pins. Each 32-bit word transfer is split into two sequential halfword accesses. A round-robin policy prevents either requester from starving the other.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of requester byte addresses and RAM halfword addresses.

Ports:
- clk  in  1  single clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high.
- i_req  in  1  instruction-side word read request; level, held until i_done.
- i_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- i_rdata  out  32  assembled read word; valid while i_done=1.
- i_done  out  1  one-cycle completion pulse.
- d_req  in  1  data-side request; level, held until d_done.
- d_we  in  1  1 = word write, 0 = word read.
- d_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- d_wdata  in  32  write word.
- d_rdata  out  32  assembled read word; valid while d_done=1.
- d_done  out  1  one-cycle completion pulse.
- ram_rd_data_in  in  16  RAM read data; valid one cycle after ram_rd_addr_out.
- ram_rd_addr_out  out  ADDR_WIDTH  RAM halfword read address.
- ram_wr_addr_out  out  ADDR_WIDTH  RAM halfword write address.
- ram_wr_data_out  out  16  RAM write data.
- ram_wr_en  out  1  RAM write strobe.
- busy  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: the only state that samples requests.
  - RD_LO: drives the low-halfword read address.
  - RD_HI: drives the high-halfword read address; captures the low halfword.
  - RD_CAP: captures the high halfword.
  - WR_LO: writes the low halfword.
  - WR_HI: writes the high halfword.
  - DONE: pulses the owner's done output, then returns to IDLE.
- Arbitration in IDLE:
  - Only one requester active: it is granted.
  - Both active: the requester not in last_owner is granted.
  - last_owner updates at each grant and resets to INST, so data wins the first tie.
- At grant, the arbiter latches owner, op (instruction side is always a read), addr and wdata. Later changes on the requester inputs have no effect on the transaction in flight.
- Address mapping:
  - Low half = {addr[ADDR_WIDTH-1:2], 1'b0}.
  - High half = low half + 1 (halfword units, i.e. byte address >> 1).
- Data mapping:
  - Write: low half = wdata[15:0], high half = wdata[31:16].
  - Read: rdata = {hi, lo}.
- Read path: IDLE → RD_LO → RD_HI → RD_CAP → DONE → IDLE.
- Write path: IDLE → WR_LO → WR_HI → DONE → IDLE.
- ram_wr_en is high only in WR_LO and WR_HI. In all other states ram_wr_en=0 and ram_wr_data_out=0.
- Only the owner's done pulses. The other requester's rdata holds its last value.
- If a requester drops req mid-transaction, the transaction still completes and done still pulses.

## Timing
- Reset state: IDLE. All outputs 0, including both rdata buses. last_owner=INST.
- Read: grant sampled in cycle 0 (IDLE); done in cycle 4. rdata stays stable until the next read completes for that owner.
- Write: grant in cycle 0; RAM writes in cycles 1 and 2; done in cycle 3.
- Handshake: req must be low by the cycle after done. A req still high in that IDLE cycle starts a new transaction.
- Minimum request-to-request spacing: 5 cycles for reads, 4 for writes. No overlap or pipelining.
- Reset asserted mid-transaction:
  - Next cycle is IDLE with ram_wr_en=0.
  - Remaining halfword is not written.
  - No done pulse is issued.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; the arbiter applies no range check.

## Structure
- package_project_typedefs holds two enums:
  - RamArbState: IDLE, RD_LO, RD_HI, RD_CAP, WR_LO, WR_HI, DONE.
  - RamRequester: REQ_INST, REQ_DATA.
- Single module; no sub-module. The FSM, grant logic and half-assembly registers fit in one block.

## Test plan
- Read, instruction side:
  - Setup: RAM model halfword 0x200=0xBEEF, 0x201=0xDEAD; drive i_req with i_addr=0x400.
  - Expect: ram_rd_addr_out=0x200 in cycle 1 and 0x201 in cycle 2.
  - Expect: i_done in cycle 4 with i_rdata=0xDEADBEEF.
- Write, data side:
  - Stimulus: d_we=1, d_addr=0x800, d_wdata=0x12345678.
  - Expect: ram_wr_en=1 at 0x400/0x5678 in cycle 1 and 0x401/0x1234 in cycle 2.
  - Expect: d_done in cycle 3; ram_wr_en=0 otherwise.
- Simultaneous requests after reset:
  - Stimulus: i_req and d_req (read) rise together.
  - Expect: data served first (d_done cycle 4), then instruction (i_done cycle 9).
  - Expect: after a further tie, instruction is served first.
- Reset mid-write:
  - Stimulus: assert reset during WR_LO.
  - Expect: next cycle IDLE, ram_wr_en=0, halfword 0x401 untouched, d_done never pulses, all outputs 0.
- Held request and address ignore:
  - Stimulus 1: keep d_req high one extra cycle after d_done.
  - Expect: a second data transaction starts from IDLE.
  - Stimulus 2: d_addr=0x803.
  - Expect: the same halfwords 0x400/0x401 are accessed.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared state and requester enums for the RAM arbiter
package package_project_typedefs;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    RD_CAP,
    WR_LO,
    WR_HI,
    DONE
  } RamArbState;

  typedef enum logic {
    REQ_INST,
    REQ_DATA
  } RamRequester;

endpackage

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter splitting 32-bit word transfers into two 16-bit RAM accesses
module ram_arbiter
  import package_project_typedefs::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [31:0]           i_rdata,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic [31:0]           d_rdata,
  output logic                  d_done,
  input  logic [15:0]           ram_rd_data_in,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_out,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_out,
  output logic [15:0]           ram_wr_data_out,
  output logic                  ram_wr_en,
  output logic                  busy
);

  RamArbState            state_q, state_d;
  RamRequester           owner_q, owner_d;
  RamRequester           last_owner_q, last_owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [15:0]           lo_q, lo_d;
  logic [31:0]           i_rdata_q, i_rdata_d;
  logic [31:0]           d_rdata_q, d_rdata_d;
  logic                  grant_data;
  logic [ADDR_WIDTH-1:0] addr_hi;

  // Byte bits [1:0] only select bytes within the word and are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  assign addr_hi = addr_q + ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= REQ_INST;
      last_owner_q <= REQ_INST;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lo_d         = lo_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant_data   = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // On a tie the side that did not own the port last time wins.
          grant_data   = d_req && (!i_req || last_owner_q == REQ_INST);
          owner_d      = grant_data ? REQ_DATA : REQ_INST;
          last_owner_d = owner_d;
          we_d         = grant_data && d_we;
          addr_d       = grant_data ? {1'b0, d_addr[ADDR_WIDTH-1:2], 1'b0}
                                    : {1'b0, i_addr[ADDR_WIDTH-1:2], 1'b0};
          wdata_d      = grant_data ? d_wdata : 32'h0;
          state_d      = we_d ? WR_LO : RD_LO;
        end
      end
      RD_LO:  state_d = RD_HI;
      RD_HI: begin
        lo_d    = ram_rd_data_in;
        state_d = RD_CAP;
      end
      RD_CAP: begin
        if (owner_q == REQ_DATA) d_rdata_d = {ram_rd_data_in, lo_q};
        else                     i_rdata_d = {ram_rd_data_in, lo_q};
        state_d = DONE;
      end
      WR_LO:  state_d = WR_HI;
      WR_HI:  state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_rd_addr_out = '0;
    ram_wr_addr_out = '0;
    ram_wr_data_out = '0;
    ram_wr_en       = 1'b0;
    i_done          = 1'b0;
    d_done          = 1'b0;

    case (state_q)
      RD_LO: ram_rd_addr_out = addr_q;
      RD_HI: ram_rd_addr_out = addr_hi;
      WR_LO: begin
        ram_wr_en       = 1'b1;
        ram_wr_addr_out = addr_q;
        ram_wr_data_out = wdata_q[15:0];
      end
      WR_HI: begin
        ram_wr_en       = 1'b1;
        ram_wr_addr_out = addr_hi;
        ram_wr_data_out = wdata_q[31:16];
      end
      DONE: begin
        i_done = (owner_q == REQ_INST);
        d_done = (owner_q == REQ_DATA);
      end
      default: ;
    endcase
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != IDLE);

endmodule
